edge_frame_vga_transmitter: RTL

Transmit end of the edge-detection datapath: accepts processed 8-bit edge pixels tagged with frame column/row and regenerates a 640x480@60 VGA stream (pixel clock, HSYNC, VSYNC, data valid, 24-bit RGB) for the display. Sits downstream of the Sobel stage and mirrors the VGA receive interface of the colorspace/matrix front end. A two-row ping-pong line buffer decouples the bursty processed-pixel writes from the fixed raster.

---
 rtl/edge_frame_vga_transmitter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/edge_frame_vga_transmitter.sv
// 640x480@60 VGA transmitter: a two-row ping-pong line buffer is filled by processed edge pixels
// and read back by a fixed raster. Define EDGE_TX_THRESHOLD_EN for a binary (thresholded) edge map.
module edge_frame_vga_transmitter #(
  parameter int                          P_FRAME_COLUMNS  = 640,
  parameter int                          P_FRAME_ROWS     = 480,
  parameter int                          P_PIXEL_DEPTH    = 24,
  parameter int                          P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
  parameter int                          P_CLK_DIV        = 4,
  parameter logic [P_SUBPIXEL_DEPTH-1:0] P_THRESHOLD      = 8'd64
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
  input  logic [9:0]                  I_PIXEL_COLUMN,
  input  logic [8:0]                  I_PIXEL_ROW,
  input  logic                        I_PIXEL_VALID,
  output logic                        O_PIXEL_CLK,
  output logic                        O_HSYNC,
  output logic                        O_VSYNC,
  output logic                        O_DATA_VALID,
  output logic [P_PIXEL_DEPTH-1:0]    O_PIXEL,
  output logic                        O_LINE_MISS
);
  localparam int            PW           = (P_CLK_DIV > 2) ? $clog2(P_CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST      = PW'(P_CLK_DIV - 1);
  localparam logic [PW-1:0] PH_READ      = PW'(P_CLK_DIV - 2);
  localparam logic [PW-1:0] PH_HIGH      = PW'(P_CLK_DIV / 2);
  localparam logic [9:0]    H_ACTIVE     = 10'(P_FRAME_COLUMNS);
  localparam logic [9:0]    H_SYNC_START = 10'd656;
  localparam logic [9:0]    H_SYNC_END   = 10'd751;
  localparam logic [9:0]    H_LAST       = 10'd799;
  localparam logic [9:0]    V_ACTIVE     = 10'(P_FRAME_ROWS);
  localparam logic [9:0]    V_SYNC_START = 10'd490;
  localparam logic [9:0]    V_SYNC_END   = 10'd491;
  localparam logic [9:0]    V_LAST       = 10'd524;
  localparam logic [8:0]    TAG_INVALID  = 9'h1FF;
`ifdef EDGE_TX_THRESHOLD_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  logic [P_SUBPIXEL_DEPTH-1:0] line_mem [2][P_FRAME_COLUMNS];
  logic [P_SUBPIXEL_DEPTH-1:0] rd_data_q;
  logic [P_SUBPIXEL_DEPTH-1:0] sub_px;
  logic [PW-1:0]               phase_q, phase_d;
  logic [9:0]                  h_q, h_d, v_q, v_d;
  logic [1:0][8:0]             tag_q, tag_d;
  logic                        line_blank_q, line_blank_d;
  logic                        pclk_q, pclk_d;
  logic                        hsync_q, hsync_d;
  logic                        vsync_q, vsync_d;
  logic                        de_q, de_d;
  logic [P_PIXEL_DEPTH-1:0]    pixel_q, pixel_d;
  logic                        line_miss_q, line_miss_d;
  logic                        wr_en, tick, active, row_start, tag_miss;
  logic [9:0]                  rd_col;

  assign wr_en  = I_PIXEL_VALID && (I_PIXEL_COLUMN < H_ACTIVE) && ({1'b0, I_PIXEL_ROW} < V_ACTIVE);
  assign rd_col = (h_q < H_ACTIVE) ? h_q : '0;
  assign sub_px = THRESH_EN ? ((rd_data_q >= P_THRESHOLD) ? '1 : '0) : rd_data_q;

  // Nonblocking read and write on the same edge give read-before-write on a bank collision.
  always_ff @(posedge I_CLK) begin
    if (wr_en) line_mem[I_PIXEL_ROW[0]][I_PIXEL_COLUMN] <= I_PIXEL;
    if (phase_q == PH_READ) rd_data_q <= line_mem[v_q[0]][rd_col];
  end

  // h_q/v_q hold the position presented at the next pixel tick, so outputs register with it.
  always_comb begin
    tick         = (phase_q == PH_LAST);
    phase_d      = tick ? '0 : phase_q + 1'b1;
    pclk_d       = (phase_d >= PH_HIGH);
    active       = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    row_start    = (h_q == '0) && (v_q < V_ACTIVE);
    tag_miss     = (tag_q[v_q[0]] != v_q[8:0]);
    h_d          = h_q;
    v_d          = v_q;
    tag_d        = tag_q;
    line_blank_d = line_blank_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    de_d         = de_q;
    pixel_d      = pixel_q;
    line_miss_d  = 1'b0;
    if (tick) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
      if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      if (row_start) begin
        line_blank_d = tag_miss;
        line_miss_d  = tag_miss;
      end
      hsync_d = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
      vsync_d = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
      de_d    = active;
      pixel_d = (active && !line_blank_d) ? {3{sub_px}} : '0;
    end
    if (wr_en) tag_d[I_PIXEL_ROW[0]] = I_PIXEL_ROW;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      phase_q      <= '0;
      h_q          <= '0;
      v_q          <= '0;
      tag_q        <= {2{TAG_INVALID}};
      line_blank_q <= 1'b1;
      pclk_q       <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      pixel_q      <= '0;
      line_miss_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      h_q          <= h_d;
      v_q          <= v_d;
      tag_q        <= tag_d;
      line_blank_q <= line_blank_d;
      pclk_q       <= pclk_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      pixel_q      <= pixel_d;
      line_miss_q  <= line_miss_d;
    end
  end

  assign O_PIXEL_CLK  = pclk_q;
  assign O_HSYNC      = hsync_q;
  assign O_VSYNC      = vsync_q;
  assign O_DATA_VALID = de_q;
  assign O_PIXEL      = pixel_q;
  assign O_LINE_MISS  = line_miss_q;
endmodule
